// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, default widths and RAM command codes for spi_slave
package spi_pkg;
  localparam int FRAME_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_if.sv
// spi_if: SPI pins plus the RAM-side frame / read-data handshake
interface spi_if import spi_pkg::*; #(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic [FRAME_W-1:0] rx_data;
  logic rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  modport master (output SS_n, MOSI, tx_data, tx_valid, input MISO, rx_data, rx_valid);
  modport slave (input SS_n, MOSI, tx_data, tx_valid, output MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: MSB-first parallel-to-serial readout of one RAM word
module spi_tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         miso,
  output logic         done
);
  localparam int CW = $clog2(W);
  logic [W-1:0] sr;
  logic [CW-1:0] cnt;
  logic busy;
  assign miso = busy & sr[W-1];
  assign done = busy && cnt == CW'(W - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (clr) begin
      sr <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (load) begin
      sr <= data;
      cnt <= '0;
      busy <= 1'b1;
    end else if (busy && shift) begin
      sr <= sr << 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI frame receiver and RAM read-back slave clocked directly by SCK.
// Define SPI_FRAME_ERR_EN to add the frame_err abort strobe.
module spi_slave import spi_pkg::*; #(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SPI_FRAME_ERR_EN
  output logic frame_err,
`endif
  spi_if.slave bus
);
  state_t state;
  logic [3:0] cnt;
  logic [FRAME_W-1:0] sr;
  logic rd_addr_done, wait_ss, post, loaded, abort, last, load, done, miso;
  assign abort = state != IDLE && bus.SS_n;
  assign last = cnt == 4'(FRAME_W - 2);
  // readout starts only after the rx_valid cycle and at most once per frame
  assign load = post && !loaded && !bus.rx_valid && bus.tx_valid && !bus.SS_n;
  assign bus.MISO = miso;
  spi_tx_shifter #(.W(DATA_W)) u_tx (
    .clk(clk), .rst_n(rst_n), .clr(abort), .load(load), .shift(post),
    .data(bus.tx_data), .miso(miso), .done(done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rd_addr_done <= 1'b0;
      wait_ss <= 1'b0;
      post <= 1'b0;
      loaded <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_valid <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt <= '0;
        sr <= '0;
        post <= 1'b0;
        loaded <= 1'b0;
      end else case (state)
        IDLE: begin
          wait_ss <= wait_ss && !bus.SS_n;
          if (!bus.SS_n && !wait_ss) state <= CHK_CMD;
        end
        CHK_CMD: begin
          sr <= FRAME_W'(bus.MOSI);
          cnt <= '0;
          state <= !bus.MOSI ? WRITE : rd_addr_done ? READ_DATA : READ_ADD;
        end
        default: if (post) begin
          loaded <= loaded || load;
          if (done) begin
            state <= IDLE;
            post <= 1'b0;
            loaded <= 1'b0;
            wait_ss <= 1'b1;
          end
        end else if (last) begin
          bus.rx_data <= {sr[FRAME_W-2:0], bus.MOSI};
          bus.rx_valid <= 1'b1;
          cnt <= '0;
          sr <= '0;
          rd_addr_done <= state == READ_ADD || (state == WRITE && rd_addr_done);
          post <= state == READ_DATA;
          if (state != READ_DATA) begin
            state <= IDLE;
            wait_ss <= 1'b1;
          end
        end else begin
          sr <= {sr[FRAME_W-2:0], bus.MOSI};
          cnt <= cnt + 1'b1;
        end
      endcase
    end
`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_err <= 1'b0;
    else frame_err <= abort;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboarded frame and MISO readout checks for spi_slave with a small RAM model
module tb_spi_slave;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sticky = 1'b0;
  int tests = 0;
  int fails = 0;
  int loads = 0;
  logic [9:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [9:0] cur_rx;
  logic [7:0] mem [256];
  logic [7:0] wa, ra, ram_dout;
  logic ram_tv;
`ifdef SPI_FRAME_ERR_EN
  logic frame_err;
`endif
  spi_if bus();
  spi_slave dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SPI_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.tx_data = ram_dout;
  assign bus.tx_valid = ram_tv | sticky;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wa <= 8'h00;
      ra <= 8'h00;
      ram_dout <= 8'h00;
      ram_tv <= 1'b0;
    end else if (bus.rx_valid) begin
      case (bus.rx_data[9:8])
        CMD_WR_ADDR: wa <= bus.rx_data[7:0];
        CMD_WR_DATA: mem[wa] <= bus.rx_data[7:0];
        CMD_RD_ADDR: begin ra <= bus.rx_data[7:0]; ram_tv <= 1'b0; end
        CMD_RD_DATA: begin ram_dout <= mem[ra]; ram_tv <= 1'b1; end
        default: ;
      endcase
    end
  always @(negedge clk) begin
    if (rst_n && dut.load) loads++;
    if (rst_n && bus.rx_valid !== 1'b0) begin
      tests++;
      if (exp_rx.size() == 0) begin
        fails++;
        $display("FAIL rx_strobe unexpected: rx_data=%h rx_valid=%b", bus.rx_data, bus.rx_valid);
      end else begin
        cur_rx = exp_rx.pop_front();
        if (bus.rx_data !== cur_rx) begin
          fails++;
          $display("FAIL rx_data got=%h exp=%h", bus.rx_data, cur_rx);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic drive_bits(input logic [9:0] f, input int n);
    @(negedge clk);
    bus.SS_n = 1'b0;
    for (int i = 9; i > 9 - n; i--) begin
      @(negedge clk);
      bus.MOSI = f[i];
    end
  endtask

  task automatic send_frame(input logic [9:0] f);
    exp_rx.push_back(f);
    drive_bits(f, 10);
  endtask

  task automatic release_ss;
    @(negedge clk);
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
  endtask

  task automatic check_idle(input string name);
    tests++;
    if (dut.state !== IDLE) begin
      fails++;
      $display("FAIL %s state got=%0d exp=IDLE", name, dut.state);
    end
  endtask

  task automatic read_out(input string name);
    logic [7:0] got, exp;
    exp = exp_tx.pop_front();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.MISO !== 1'b0) begin
      fails++;
      $display("FAIL %s pre_load_miso got=%b exp=0", name, bus.MISO);
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = bus.MISO;
    end
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s miso_byte got=%h exp=%h", name, got, exp);
    end
    @(negedge clk);
    tests++;
    if (bus.MISO !== 1'b0) begin
      fails++;
      $display("FAIL %s post_miso got=%b exp=0", name, bus.MISO);
    end
    check_idle(name);
  endtask

  task automatic test_reset;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests += 4;
    if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL reset rx_data got=%h exp=000", bus.rx_data); end
    if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset rx_valid got=%b exp=0", bus.rx_valid); end
    if (bus.MISO !== 1'b0) begin fails++; $display("FAIL reset miso got=%b exp=0", bus.MISO); end
    if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL reset rd_addr_done got=%b exp=0", dut.rd_addr_done); end
    check_idle("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    send_frame(10'h03C);
    @(negedge clk);
    check_idle("wr_addr");
    release_ss();
    send_frame(10'h1A5);
    @(negedge clk);
    check_idle("wr_data");
    release_ss();
    @(negedge clk);
    tests++;
    if (mem[8'h3C] !== 8'hA5) begin
      fails++;
      $display("FAIL ram_store got=%h exp=a5", mem[8'h3C]);
    end
  endtask

  task automatic test_read_pair;
    send_frame(10'h23C);
    @(negedge clk);
    tests++;
    if (dut.rd_addr_done !== 1'b1) begin fails++; $display("FAIL rd_addr rd_addr_done got=%b exp=1", dut.rd_addr_done); end
    check_idle("rd_addr");
    release_ss();
    exp_tx.push_back(8'hA5);
    send_frame(10'h300);
    read_out("rd_data");
    tests++;
    if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rd_data rd_addr_done got=%b exp=0", dut.rd_addr_done); end
    release_ss();
  endtask

  task automatic test_ignore_after_done;
    send_frame(10'h03C);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.MOSI = i[0];
    end
    check_idle("ignore");
    release_ss();
  endtask

  task automatic test_abort;
    drive_bits(10'h1A5, 5);
    @(negedge clk);
    bus.SS_n = 1'b1;
    @(negedge clk);
    check_idle("abort");
    tests++;
    if (dut.cnt !== 4'd0) begin fails++; $display("FAIL abort cnt got=%0d exp=0", dut.cnt); end
`ifdef SPI_FRAME_ERR_EN
    tests++;
    if (frame_err !== 1'b1) begin fails++; $display("FAIL abort frame_err got=%b exp=1", frame_err); end
    @(negedge clk);
    tests++;
    if (frame_err !== 1'b0) begin fails++; $display("FAIL abort frame_err_end got=%b exp=0", frame_err); end
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sticky;
    sticky = 1'b1;
    loads = 0;
    send_frame(10'h010);
    release_ss();
    send_frame(10'h1C3);
    release_ss();
    send_frame(10'h210);
    release_ss();
    exp_tx.push_back(8'hC3);
    send_frame(10'h300);
    read_out("sticky1");
    tests++;
    if (loads !== 1) begin fails++; $display("FAIL sticky1 loads got=%0d exp=1", loads); end
    release_ss();
    send_frame(10'h23C);
    release_ss();
    exp_tx.push_back(8'hA5);
    send_frame(10'h300);
    read_out("sticky2");
    tests++;
    if (loads !== 2) begin fails++; $display("FAIL sticky2 loads got=%0d exp=2", loads); end
    release_ss();
    sticky = 1'b0;
  endtask

  task automatic test_reset_mid;
    send_frame(10'h23C);
    release_ss();
    drive_bits(10'h03C, 6);
    @(negedge clk);
    rst_n = 1'b0;
    bus.SS_n = 1'b1;
    #1;
    tests++;
    if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rst_frame rd_addr_done got=%b exp=0", dut.rd_addr_done); end
    check_idle("rst_frame");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(10'h23C);
    release_ss();
    send_frame(10'h300);
    repeat (5) @(negedge clk);
    tests++;
    if (bus.MISO !== 1'b1) begin fails++; $display("FAIL rst_readout miso_bit5 got=%b exp=1", bus.MISO); end
    rst_n = 1'b0;
    bus.SS_n = 1'b1;
    #1;
    tests += 3;
    if (bus.MISO !== 1'b0) begin fails++; $display("FAIL rst_readout miso got=%b exp=0", bus.MISO); end
    if (dut.rd_addr_done !== 1'b0) begin fails++; $display("FAIL rst_readout rd_addr_done got=%b exp=0", dut.rd_addr_done); end
    if (bus.rx_data !== 10'h000) begin fails++; $display("FAIL rst_readout rx_data got=%h exp=000", bus.rx_data); end
    check_idle("rst_readout");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_pair();
    test_ignore_after_done();
    test_abort();
    test_sticky();
    test_reset_mid();
    tests++;
    if (exp_rx.size() != 0 || exp_tx.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain rx_left=%0d tx_left=%0d exp=0", exp_rx.size(), exp_tx.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
